// File: rtl/hazard_ctrl.sv
// LEGv8 hazard/sequencing controller: load-use bubble, branch flush, dmem freeze, NZVC flags.
// Optional macro HAZARD_FLAG_FWD_EN forwards EX flags to ID instead of stalling B.cond.
module hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int ZERO_REG    = 31,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_bcond,
    input  logic             br_taken,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_flag_up,
    input  logic [3:0]       ex_flags,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [3:0]       flags_out,
    output logic [3:0]       flag_q,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MEM_WAIT
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
    logic             timeout_set;
    logic             lu_haz;
    logic             mem_stall;
    logic             stall_haz;

    assign lu_haz = ex_mem_read
                  & (ex_rd != REG_W'(ZERO_REG))
                  & ((id_use_rn & (id_rn == ex_rd))
                   | (id_use_rm & (id_rm == ex_rd)));

    assign mem_stall = dmem_req & ~dmem_ready;

`ifdef HAZARD_FLAG_FWD_EN
    logic unused_bcond;
    assign unused_bcond = id_bcond;
    assign stall_haz    = lu_haz;
    assign flags_out    = ex_flag_up ? ex_flags : flag_q;
`else
    // Without forwarding, B.cond must wait for the flag setter to retire to flag_q
    assign stall_haz = lu_haz | (id_bcond & ex_flag_up);
    assign flags_out = flag_q;
`endif

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        timeout_set = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        case (state)
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                    timeout_set = 1'b1;
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_hold   = 1'b1;
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = RUN;
                if (mem_stall) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_hold   = 1'b1;
                    state_nx    = MEM_WAIT;
                    wait_cnt_nx = CNT_W'(1);
                end else if (stall_haz && state == RUN) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_nx    = LU_STALL;
                end else if (br_taken) begin
                    ifid_flush = 1'b1;
                end
            end
        endcase
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_hold   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            flag_q      <= 4'b0000;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            mem_timeout <= mem_timeout | timeout_set;
            if (ex_flag_up && !pipe_hold)
                flag_q <= ex_flags;
        end
    end

endmodule
